commutator_out: RTL

//  Output commutator for the radix-4 MDC FFT: the parallel-to-serial end of the lane split made at the pipeline input.

---
 rtl/commutator_out.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/commutator_out.sv
// commutator_out: output commutator of the radix-4 MDC FFT.
// Collects BLK quads (four complex lanes each) into one of two banks. Each full
// bank is replayed as one lane-major serial stream of 4*BLK words: lane1 q0..q(BLK-1),
// then lane2, lane3 and lane4. While one bank is being read, the other can be written.
// Optional feature: define COMMUTATOR_OUT_LAST_EN to add out_last. It is high on the
// final word of every frame.
module commutator_out #(
  parameter int WL  = 16,
  parameter int BLK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Enable,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WL-1:0] in1_r,
  input  logic [WL-1:0] in1_i,
  input  logic [WL-1:0] in2_r,
  input  logic [WL-1:0] in2_i,
  input  logic [WL-1:0] in3_r,
  input  logic [WL-1:0] in3_i,
  input  logic [WL-1:0] in4_r,
  input  logic [WL-1:0] in4_i,
  output logic [WL-1:0] out_r,
  output logic [WL-1:0] out_i,
  output logic          out_valid,
  input  logic          out_ready
`ifdef COMMUTATOR_OUT_LAST_EN
  ,
  output logic          out_last
`endif
);

  localparam int IW = (BLK > 1) ? $clog2(BLK) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BLK - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  logic [WL-1:0] bank_r_q [2][4][BLK];
  logic [WL-1:0] bank_i_q [2][4][BLK];

  logic          wbank_q, wbank_d;
  logic [IW-1:0] widx_q, widx_d;
  logic          rbank_q, rbank_d;
  logic [1:0]    rlane_q, rlane_d;
  logic [IW-1:0] ridx_q, ridx_d;
  logic [1:0]    full_q, full_d;
  state_t        state_q, state_d;
  logic [WL-1:0] out_r_q, out_r_d;
  logic [WL-1:0] out_i_q, out_i_d;
  logic          out_valid_q, out_valid_d;

  logic wr_fire, wr_fill, fill_rbank, fill_other;
  logic advance, rd_avail, rd_fire, rd_last;

  // Handshake and read-availability decode shared by all processes below
  always_comb begin
    in_ready   = Enable & ~full_q[wbank_q];
    wr_fire    = in_valid & in_ready;
    wr_fill    = wr_fire & (widx_q == LAST_IDX);
    fill_rbank = wr_fill & (wbank_q == rbank_q);
    fill_other = wr_fill & (wbank_q != rbank_q);
    advance    = Enable & (~out_valid_q | out_ready);
    rd_avail   = (state_q == STREAM) | full_q[rbank_q] | fill_rbank;
    rd_fire    = advance & rd_avail;
    rd_last    = (rlane_q == 2'd3) & (ridx_q == LAST_IDX);
  end

  // Write pointer: step through the quads of a frame and swap banks after the last quad
  always_comb begin
    wbank_d = wbank_q;
    widx_d  = widx_q;
    if (wr_fire) begin
      if (wr_fill) begin
        widx_d  = '0;
        wbank_d = ~wbank_q;
      end else begin
        widx_d = widx_q + 1'b1;
      end
    end
  end

  // Bank full flags: set by the filling write and cleared by the final read; the two events can occur together
  always_comb begin
    full_d = full_q;
    if (wr_fill) full_d[wbank_q] = 1'b1;
    if (rd_fire && rd_last) full_d[rbank_q] = 1'b0;
  end

  // Read FSM: walk the bank lane-major, then continue straight into the other bank if it is ready
  always_comb begin
    state_d = state_q;
    rbank_d = rbank_q;
    rlane_d = rlane_q;
    ridx_d  = ridx_q;
    case (state_q)
      IDLE: begin
        if (rd_fire) begin
          state_d = STREAM;
          ridx_d  = ridx_q + 1'b1;
        end
      end
      STREAM: begin
        if (rd_fire) begin
          if (rd_last) begin
            ridx_d  = '0;
            rlane_d = 2'd0;
            rbank_d = ~rbank_q;
            state_d = (full_q[~rbank_q] | fill_other) ? STREAM : IDLE;
          end else if (ridx_q == LAST_IDX) begin
            ridx_d  = '0;
            rlane_d = rlane_q + 2'd1;
          end else begin
            ridx_d = ridx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register: load the next word when the consumer can take it, otherwise hold
  always_comb begin
    out_r_d     = out_r_q;
    out_i_d     = out_i_q;
    out_valid_d = out_valid_q;
    if (advance) begin
      out_valid_d = rd_fire;
      if (rd_fire) begin
        out_r_d = bank_r_q[rbank_q][rlane_q][ridx_q];
        out_i_d = bank_i_q[rbank_q][rlane_q][ridx_q];
      end
    end
  end

  // Bank storage: one quad per accepted transfer; contents are not reset
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      bank_r_q[wbank_q][0][widx_q] <= in1_r;
      bank_i_q[wbank_q][0][widx_q] <= in1_i;
      bank_r_q[wbank_q][1][widx_q] <= in2_r;
      bank_i_q[wbank_q][1][widx_q] <= in2_i;
      bank_r_q[wbank_q][2][widx_q] <= in3_r;
      bank_i_q[wbank_q][2][widx_q] <= in3_i;
      bank_r_q[wbank_q][3][widx_q] <= in4_r;
      bank_i_q[wbank_q][3][widx_q] <= in4_i;
    end
  end

  // Pointer, flag, FSM and output state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbank_q     <= 1'b0;
      widx_q      <= '0;
      rbank_q     <= 1'b0;
      rlane_q     <= 2'd0;
      ridx_q      <= '0;
      full_q      <= 2'b00;
      state_q     <= IDLE;
      out_r_q     <= '0;
      out_i_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wbank_q     <= wbank_d;
      widx_q      <= widx_d;
      rbank_q     <= rbank_d;
      rlane_q     <= rlane_d;
      ridx_q      <= ridx_d;
      full_q      <= full_d;
      state_q     <= state_d;
      out_r_q     <= out_r_d;
      out_i_q     <= out_i_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_r     = out_r_q;
  assign out_i     = out_i_q;
  assign out_valid = out_valid_q;

`ifdef COMMUTATOR_OUT_LAST_EN
  logic out_last_q, out_last_d;

  // Frame-end marker travels with the word it belongs to
  always_comb begin
    out_last_d = out_last_q;
    if (advance) out_last_d = rd_fire & rd_last;
  end

  // Frame-end marker register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_last_q <= 1'b0;
    else     out_last_q <= out_last_d;
  end

  assign out_last = out_last_q;
`endif

endmodule
